// File: rtl/decoder_scoreboard.sv
// Registered one-hot write-select decoder with busy scoreboard (1-cycle decode). Issue stalls via iss_ready on
// write-after-write hazards; `DECODER_ZERO_REG_EN makes address 0 a never-busy zero register.
module decoder_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [ADDR_W-1:0]    iss_addr,
    input  logic                 iss_wr,
    input  logic                 ret_valid,
    input  logic [ADDR_W-1:0]    ret_addr,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    chk_addr_a,
    input  logic [ADDR_W-1:0]    chk_addr_b,
    output logic                 chk_busy_a,
    output logic                 chk_busy_b,
    output logic                 dec_valid,
    output logic [2**ADDR_W-1:0] dec_onehot,
    output logic [ADDR_W:0]      busy_count,
    output logic                 err
);
    localparam int N = 2**ADDR_W;

    // Entries that participate in scoreboarding; the zero register is excluded when enabled.
`ifdef DECODER_ZERO_REG_EN
    localparam logic [N-1:0] TRACK = {{(N-1){1'b1}}, 1'b0};
`else
    localparam logic [N-1:0] TRACK = {N{1'b1}};
`endif

    logic [N-1:0]    busy_q, busy_d;
    logic            dec_valid_q, dec_valid_d;
    logic [N-1:0]    dec_onehot_q, dec_onehot_d;
    logic [ADDR_W:0] busy_count_q, busy_count_d;
    logic            err_q, err_d;
    logic            acc;
    logic            ret_hit;
    logic [N-1:0]    iss_sel;
    logic [N-1:0]    ret_sel;

    always_comb begin
        iss_sel = {{(N-1){1'b0}}, 1'b1} << iss_addr;
        ret_sel = {{(N-1){1'b0}}, 1'b1} << ret_addr;
        // A same-cycle retire of the destination resolves the hazard before the new write lands.
        iss_ready = ~flush & (~iss_wr | ~busy_q[iss_addr] | (ret_valid & (ret_addr == iss_addr)));
        acc       = iss_valid & iss_ready;
        ret_hit   = ret_valid & |(ret_sel & TRACK);

        busy_d       = busy_q;
        err_d        = err_q;
        dec_valid_d  = acc;
        dec_onehot_d = (acc & iss_wr) ? (iss_sel & TRACK) : '0;

        if (flush) begin
            busy_d       = '0;
            dec_valid_d  = 1'b0;
            dec_onehot_d = '0;
        end else begin
            if (ret_hit) begin
                if (!busy_q[ret_addr]) err_d = 1'b1;
                busy_d = busy_d & ~ret_sel;
            end
            // Set is applied after clear so a colliding issue keeps the entry busy.
            if (acc & iss_wr) busy_d = busy_d | (iss_sel & TRACK);
        end

        busy_count_d = '0;
        for (int i = 0; i < N; i++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            dec_valid_q  <= 1'b0;
            dec_onehot_q <= '0;
            busy_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            dec_valid_q  <= dec_valid_d;
            dec_onehot_q <= dec_onehot_d;
            busy_count_q <= busy_count_d;
            err_q        <= err_d;
        end
    end

    assign chk_busy_a = busy_q[chk_addr_a];
    assign chk_busy_b = busy_q[chk_addr_b];
    assign dec_valid  = dec_valid_q;
    assign dec_onehot = dec_onehot_q;
    assign busy_count = busy_count_q;
    assign err        = err_q;
endmodule

// File: tb/tb_decoder_scoreboard.sv
// Scoreboard bench: driver predicts decodes into a queue from a behavioural busy-set model; monitor pops and compares.
module tb_decoder_scoreboard;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          iss_valid, iss_ready, iss_wr;
    logic [AW-1:0] iss_addr;
    logic          ret_valid;
    logic [AW-1:0] ret_addr;
    logic          flush;
    logic [AW-1:0] chk_addr_a, chk_addr_b;
    logic          chk_busy_a, chk_busy_b;
    logic          dec_valid;
    logic [N-1:0]  dec_onehot;
    logic [AW:0]   busy_count;
    logic          err;

    decoder_scoreboard #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr), .iss_wr(iss_wr),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .flush(flush),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .chk_busy_a(chk_busy_a), .chk_busy_b(chk_busy_b),
        .dec_valid(dec_valid), .dec_onehot(dec_onehot), .busy_count(busy_count), .err(err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    bit           mon_en   = 1'b0;
    bit           mbusy[N];
    bit           merr;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    function automatic bit tracked(input int a);
`ifdef DECODER_ZERO_REG_EN
        return a != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    function automatic int pick_busy();
        int s = $urandom_range(0, N-1);
        for (int i = 0; i < N; i++) if (mbusy[(s+i)%N]) return (s+i)%N;
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    endtask

    task automatic step(input bit v, input bit wr, input int a, input bit rv, input int ra,
                        input bit fl, input int ca);
        bit           rdy;
        logic [N-1:0] oh;
        @(negedge clk);
        iss_valid = v;  iss_wr = wr;  iss_addr = a[AW-1:0];
        ret_valid = rv; ret_addr = ra[AW-1:0]; flush = fl;
        chk_addr_a = ca[AW-1:0]; chk_addr_b = a[AW-1:0];
        #1;
        rdy = !fl && (!wr || !mbusy[a] || (rv && ra == a));
        chk("iss_ready", iss_ready, rdy);
        chk("chk_busy_a", chk_busy_a, mbusy[ca]);
        chk("chk_busy_b", chk_busy_b, mbusy[a]);
        if (fl) begin
            model_clear();
        end else begin
            if (rv && tracked(ra)) begin
                if (!mbusy[ra]) merr = 1'b1;
                mbusy[ra] = 1'b0;
            end
            if (v && rdy) begin
                oh = '0;
                if (wr && tracked(a)) begin
                    oh[a] = 1'b1;
                    mbusy[a] = 1'b1;
                end
                exp_q.push_back(oh);
            end
        end
        @(posedge clk);
    endtask

    // Monitor: samples just after each rising edge, independent of the driver.
    initial begin
        logic [N-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (dec_valid) begin
                    if (exp_q.size() == 0) chk("dec_spurious", dec_valid, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chk("dec_onehot", dec_onehot, e);
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        chk("dec_missing", dec_valid, 1'b1);
                        void'(exp_q.pop_front());
                    end
                    chk("dec_onehot_idle", dec_onehot, '0);
                end
                chk("busy_count", busy_count, mcount());
                chk("err", err, merr);
            end
        end
    end

    initial begin
        bit fl, rv, v, wr;
        int a, ra, sel;
        reset = 1'b1; iss_valid = 0; iss_wr = 0; iss_addr = '0; ret_valid = 0; ret_addr = '0;
        flush = 0; chk_addr_a = 5'd7; chk_addr_b = '0;
        model_clear(); merr = 1'b0;
        #12;
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_onehot", dec_onehot, '0);
        chk("rst_busy_count", busy_count, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_chk_busy", chk_busy_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        // Write 7, then WAW stall, then stall resolved by same-cycle retire.
        step(1, 1, 7, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);
        step(1, 1, 7, 0, 0, 0, 7);
        step(1, 1, 7, 1, 7, 0, 7);
        step(0, 0, 0, 1, 7, 0, 7);
        // Fill every entry back-to-back, then a write stalls while a non-write passes.
        for (int i = 0; i < N; i++) step(1, 1, i, 0, 0, 0, i);
        step(1, 1, 5, 0, 0, 0, 5);
        step(1, 0, 5, 0, 0, 0, 5);
        step(1, 1, 9, 0, 0, 1, 9);
        // Retire of an idle entry raises the sticky error.
        step(0, 0, 0, 1, 3, 0, 3);
        step(0, 0, 0, 0, 0, 0, 3);
        for (int i = 10; i < 15; i++) step(1, 1, i, 0, 0, 0, i);
        step(1, 1, 20, 0, 0, 1, 12);

        for (int k = 0; k < 300; k++) begin
            fl  = ($urandom_range(0, 49) == 0);
            rv  = !fl && ($urandom_range(0, 99) < 40);
            ra  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N-1)) : pick_busy();
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? pick_busy() : (sel == 1) ? ra : int'($urandom_range(0, N-1));
            v   = ($urandom_range(0, 99) < 75);
            wr  = ($urandom_range(0, 99) < 80);
            step(v, wr, a, rv, ra, fl, $urandom_range(0, N-1));
        end

        // Asynchronous reset between edges.
        #3;
        iss_valid = 0; ret_valid = 0; flush = 0;
        reset = 1'b1;
        #1;
        model_clear(); merr = 1'b0; exp_q.delete();
        chk("arst_dec_valid", dec_valid, 1'b0);
        chk("arst_dec_onehot", dec_onehot, '0);
        chk("arst_busy_count", busy_count, 0);
        chk("arst_err", err, 1'b0);
        chk("arst_iss_ready", iss_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Address 0 write and retire; behaviour depends on the zero-register option.
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 200; k++) begin
            fl  = ($urandom_range(0, 63) == 0);
            rv  = !fl && ($urandom_range(0, 99) < 30);
            ra  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N-1)) : pick_busy();
            a   = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, N-1));
            v   = ($urandom_range(0, 99) < 85);
            wr  = ($urandom_range(0, 99) < 90);
            step(v, wr, a, rv, ra, fl, a ^ 1);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decoder_scoreboard.md
# decoder_scoreboard

Parametrised, registered address decoder with an integrated busy scoreboard for the register-file write path. Each accepted issue decodes a destination address into a one-hot write-select vector one cycle later. When the issue writes, it also marks that entry busy until a matching retire. Issue stalls on a write-after-write hazard, and two read-side check ports report pending writes for hazard detection ahead of the register file.

## Interface
- `ADDR_W`, 5, address width; entry count `N = 2**ADDR_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `iss_valid`  in  1  issue request.
- `iss_ready`  out  1  issue may be accepted this cycle (combinational).
- `iss_addr`  in  ADDR_W  destination address.
- `iss_wr`  in  1  issue writes its destination; marks the entry busy.
- `ret_valid`  in  1  retire strobe; clears busy for `ret_addr`.
- `ret_addr`  in  ADDR_W  retired address.
- `flush`  in  1  synchronous clear of all busy bits and the pending decode.
- `chk_addr_a`, `chk_addr_b`  in  ADDR_W each  read-side check addresses.
- `chk_busy_a`, `chk_busy_b`  out  1 each  combinational `busy[chk_addr]`.
- `dec_valid`  out  1  `dec_onehot` is valid.
- `dec_onehot`  out  N  one-hot select; bit i corresponds to address i.
- `busy_count`  out  ADDR_W+1  number of set busy bits.
- `err`  out  1  sticky error flag.

## Operation
- Accept: `acc = iss_valid & iss_ready`.
- `iss_ready = ~flush & (~iss_wr | ~busy[iss_addr] | (ret_valid & ret_addr == iss_addr))`.
- On `acc`:
  - `dec_onehot <= (iss_wr ? 1 << iss_addr : 0)`.
  - `dec_valid <= 1`.
  - If `iss_wr`, set `busy[iss_addr]`.
- With no `acc`: `dec_valid <= 0` and `dec_onehot <= 0`. The output is a single-cycle pulse per accepted issue.
- Retire clears `busy[ret_addr]`. When a retire and an issue target the same address in the same cycle, the set wins, so the entry stays busy for the new write.
- Retire of a non-busy entry sets `err`. `err` is cleared only by `reset`. The busy vector is unaffected.
- `flush` has priority over issue and retire. The next state is all busy bits 0, `dec_valid = 0`, `dec_onehot = 0`.
- `busy_count` is registered and equals the popcount of the busy vector after the same edge. Width `ADDR_W+1` holds the full value `N`.
- Check ports read the current registered busy vector. A retire in the same cycle is not forwarded.

## Timing
- Reset values:
  - all busy bits 0
  - `dec_valid` 0, `dec_onehot` 0
  - `busy_count` 0
  - `err` 0
  - `iss_ready` follows from the reset state: 1 unless `flush` is asserted.
- Decode latency is 1 cycle: accept at edge k, so `dec_valid` and `dec_onehot` are valid after edge k.
- Back-to-back accepts give a continuous `dec_valid` stream, one vector per cycle.
- Busy set/clear is visible on `chk_busy_*` and `iss_ready` in the cycle after the edge.
- Reset mid-operation: all state clears immediately and asynchronously. Any in-flight decode is dropped.
- Full scoreboard (`busy_count == N`): any `iss_wr` issue stalls unless a same-address retire arrives. `iss_wr = 0` issues still pass and produce `dec_onehot = 0`.

## Configuration
- `DECODER_ZERO_REG_EN` defined:
  - Address 0 is the hardwired zero register and is never marked busy.
  - `dec_onehot[0]` is always 0, while `dec_valid` still pulses.
  - `chk_busy_*` is 0 for address 0.
  - A retire of address 0 is ignored and does not set `err`.
  - `iss_ready` ignores busy for address 0.
- Not defined: address 0 is treated like every other entry.

## Test plan
- Reset, then issue addr 7 with `iss_wr = 1`: after 1 edge, `dec_valid = 1` and `dec_onehot = 1 << 7`; next cycle `chk_busy_a(7) = 1` and `busy_count = 1`.
- WAW stall: with addr 7 busy, re-issue addr 7 and observe `iss_ready = 0`. Retire 7 in the same cycle: `iss_ready = 1`, accepted, entry 7 still busy, `busy_count` stays 1.
- Fill all 32 entries back-to-back: expect 32 consecutive `dec_valid` pulses, then `busy_count = 32`; a further write issue stalls and an `iss_wr = 0` issue passes.
- Retire addr 3 while it is not busy: `err = 1` and stays 1 until `reset`; busy vector unchanged.
- Flush with 5 entries busy and an issue valid: after 1 edge, `busy_count = 0`, `dec_valid = 0`, and the issue was not accepted. Then assert `reset` mid-stream and confirm all outputs go to their reset values asynchronously.
- With `DECODER_ZERO_REG_EN`: issue addr 0 with `iss_wr = 1` gives `dec_valid = 1`, `dec_onehot = 0`, `busy_count = 0`, `chk_busy(0) = 0`; retire addr 0 leaves `err = 0`.
